// File: rtl/cpu_intr_ctrl_if.sv
// Interrupt controller bus: request lines, config port,
// retire-boundary inputs and redirect / status outputs.
interface cpu_intr_ctrl_if #(
  parameter int N_SRC = 4,
  parameter int XLEN  = 32
);
  localparam int AW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] irq;
  logic             cfg_we;
  logic [2:0]       cfg_sel;
  logic [XLEN-1:0]  cfg_wdata;
  logic             cpu_retire;
  logic [XLEN-1:0]  cpu_pc;
  logic             cpu_iret;
  logic             take;
  logic [XLEN-1:0]  take_pc;
  logic [XLEN-1:0]  epc;
  logic             in_service;
  logic [AW-1:0]    active_id;
  logic [N_SRC-1:0] pending;

  modport master (
    output irq, cfg_we, cfg_sel, cfg_wdata,
    output cpu_retire, cpu_pc, cpu_iret,
    input  take, take_pc, epc, in_service,
    input  active_id, pending
  );

  modport slave (
    input  irq, cfg_we, cfg_sel, cfg_wdata,
    input  cpu_retire, cpu_pc, cpu_iret,
    output take, take_pc, epc, in_service,
    output active_id, pending
  );
endinterface

// File: rtl/cpu_intr_ctrl.sv
// Prioritised multi-source interrupt controller with per-source
// enable and level/edge mode, one-cycle redirect and iret restore.
module cpu_intr_ctrl #(
  parameter int              N_SRC     = 4,
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] VEC_RESET = 'h0000_0100
) (
  input logic           clk,
  input logic           rst_n,
  cpu_intr_ctrl_if.slave bus
);
  localparam int AW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    TAKE,
    SERV
  } st_t;

  st_t st, st_nx;

  logic [N_SRC-1:0] en_q, edge_q, irq_q, lat_q;
  logic [N_SRC-1:0] pend_v, req, w1c, clr, one;
  logic [XLEN-1:0]  base_q, tpc_q, epc_q;
  logic [AW-1:0]    id_q, win;
  logic             ie_q, pie_q, fire;
  logic             wr_en, wr_edge, wr_base, wr_ie, wr_w1c;

  assign wr_en   = bus.cfg_we && bus.cfg_sel == 3'd0;
  assign wr_edge = bus.cfg_we && bus.cfg_sel == 3'd1;
  assign wr_base = bus.cfg_we && bus.cfg_sel == 3'd2;
  assign wr_ie   = bus.cfg_we && bus.cfg_sel == 3'd3;
  assign wr_w1c  = bus.cfg_we && bus.cfg_sel == 3'd4;

  // Edges are latched for every source; only edge-mode ones show it.
  assign pend_v = (edge_q & lat_q) | (~edge_q & bus.irq);
  assign req    = pend_v & en_q;

  always_comb begin
    win = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (req[i]) win = AW'(i);
  end

  always_comb begin
    one      = '0;
    one[win] = 1'b1;
  end

  assign fire = (st == IDLE) && ie_q && (|req)
             && bus.cpu_retire && !bus.cpu_iret;

  assign w1c = wr_w1c ? bus.cfg_wdata[N_SRC-1:0] : '0;
  assign clr = w1c | ((fire && edge_q[win]) ? one : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:    if (fire) st_nx = TAKE;
      TAKE:    st_nx = SERV;
      SERV:    if (bus.cpu_iret) st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.take       = (st == TAKE);
    bus.take_pc    = (st == TAKE) ? tpc_q : '0;
    bus.in_service = (st != IDLE);
  end

  assign bus.epc       = epc_q;
  assign bus.active_id = id_q;
  assign bus.pending   = pend_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= '0;
      edge_q <= '0;
      irq_q  <= '0;
      lat_q  <= '0;
      base_q <= VEC_RESET;
      tpc_q  <= '0;
      epc_q  <= '0;
      id_q   <= '0;
      ie_q   <= 1'b0;
      pie_q  <= 1'b0;
    end else begin
      irq_q <= bus.irq;
      lat_q <= (lat_q & ~clr) | (bus.irq & ~irq_q);
      if (wr_en)   en_q   <= bus.cfg_wdata[N_SRC-1:0];
      if (wr_edge) edge_q <= bus.cfg_wdata[N_SRC-1:0];
      if (wr_base) base_q <= bus.cfg_wdata;
      // Taking the interrupt beats a same-cycle IE write.
      if (fire) begin
        epc_q <= bus.cpu_pc;
        id_q  <= win;
        tpc_q <= base_q + (XLEN'(win) << 2);
        pie_q <= ie_q;
        ie_q  <= 1'b0;
      end else if (st == SERV && bus.cpu_iret) begin
        ie_q <= pie_q;
      end else if (wr_ie) begin
        ie_q <= bus.cfg_wdata[0];
      end
    end
  end
endmodule

// File: tb/tb_cpu_intr_ctrl.sv
// Directed bench for cpu_intr_ctrl with a cycle-level reference
// model compared every cycle plus literal spot checks.
module tb_cpu_intr_ctrl;
  logic clk = 0;
  logic rst_n = 1;
  bit   armed = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cpu_intr_ctrl_if #(.N_SRC(4), .XLEN(32)) bus ();

  cpu_intr_ctrl #(
    .N_SRC(4), .XLEN(32), .VEC_RESET(32'h100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  // Reference model: architectural state only
  bit [3:0]    m_en = 0, m_edge = 0, m_prev = 0, m_lat = 0;
  logic [31:0] m_base = 32'h100, m_epc = 0, m_tpc = 0;
  bit          m_ie = 0, m_pie = 0;
  int          m_mode = 0;
  int          m_id = 0;

  function automatic bit [3:0] m_pend();
    bit [3:0] p;
    for (int i = 0; i < 4; i++)
      p[i] = m_edge[i] ? m_lat[i] : bus.irq[i];
    return p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en = 0; m_edge = 0; m_prev = 0; m_lat = 0;
      m_base = 32'h100; m_epc = 0; m_tpc = 0;
      m_ie = 0; m_pie = 0; m_mode = 0; m_id = 0;
    end else begin
      bit [3:0] req;
      bit fire;
      int w;
      int old_mode;
      req = m_pend() & m_en;
      fire = 0;
      w = 0;
      old_mode = m_mode;
      if (m_mode == 0 && m_ie && req != 0
          && bus.cpu_retire && !bus.cpu_iret) begin
        fire = 1;
        for (int i = 3; i >= 0; i--) if (req[i]) w = i;
      end
      for (int i = 0; i < 4; i++) begin
        bit s, c;
        s = bus.irq[i] && !m_prev[i];
        c = (bus.cfg_we && bus.cfg_sel == 4 && bus.cfg_wdata[i])
            || (fire && w == i && m_edge[i]);
        if (s) m_lat[i] = 1;
        else if (c) m_lat[i] = 0;
      end
      m_prev = bus.irq;
      if (fire) begin
        m_pie = m_ie; m_ie = 0;
        m_epc = bus.cpu_pc; m_id = w;
        m_tpc = m_base + 32'(4 * w);
        m_mode = 1;
      end else if (old_mode == 1) begin
        m_mode = 2;
      end else if (old_mode == 2 && bus.cpu_iret) begin
        m_ie = m_pie; m_mode = 0;
      end
      if (bus.cfg_we && bus.cfg_sel == 3 && !fire
          && !(old_mode == 2 && bus.cpu_iret))
        m_ie = bus.cfg_wdata[0];
      if (bus.cfg_we && bus.cfg_sel == 0) m_en = bus.cfg_wdata[3:0];
      if (bus.cfg_we && bus.cfg_sel == 1) m_edge = bus.cfg_wdata[3:0];
      if (bus.cfg_we && bus.cfg_sel == 2) m_base = bus.cfg_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("take", 32'(bus.take), 32'(m_mode == 1));
      chk("take_pc", bus.take_pc, (m_mode == 1) ? m_tpc : 32'h0);
      chk("in_service", 32'(bus.in_service), 32'(m_mode != 0));
      chk("epc", bus.epc, m_epc);
      chk("active_id", 32'(bus.active_id), 32'(m_id));
      chk("pending", 32'(bus.pending), 32'(m_pend()));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
    bus.cfg_we = 0;
    bus.cpu_retire = 0;
    bus.cpu_iret = 0;
  endtask

  task automatic cfg(input int sel, input logic [31:0] d);
    bus.cfg_we = 1;
    bus.cfg_sel = 3'(sel);
    bus.cfg_wdata = d;
    step();
  endtask

  task automatic retire(input logic [31:0] pc);
    bus.cpu_retire = 1;
    bus.cpu_pc = pc;
    step();
  endtask

  task automatic iret();
    bus.cpu_iret = 1;
    step();
  endtask

  task automatic pulse(input logic [3:0] v);
    bus.irq = v;
    step();
    bus.irq = 0;
    step();
  endtask

  initial begin
    bus.irq = 0; bus.cfg_we = 0; bus.cfg_sel = 0; bus.cfg_wdata = 0;
    bus.cpu_retire = 0; bus.cpu_pc = 0; bus.cpu_iret = 0;
    #3 rst_n = 0;
    armed = 1;
    step(2);
    chk("rst_take", 32'(bus.take), 0);
    chk("rst_epc", bus.epc, 0);
    chk("rst_insvc", 32'(bus.in_service), 0);
    rst_n = 1;
    step();

    // single edge source
    cfg(2, 32'h100); cfg(0, 4); cfg(1, 4); cfg(3, 1);
    pulse(4);
    chk("t1_pend", 32'(bus.pending), 4);
    retire(32'h40);
    chk("t1_take", 32'(bus.take), 1);
    chk("t1_tpc", bus.take_pc, 32'h108);
    chk("t1_epc", bus.epc, 32'h40);
    chk("t1_id", 32'(bus.active_id), 2);
    step();
    chk("t1_svc", 32'(bus.in_service), 1);
    iret();
    chk("t1_ret", 32'(bus.in_service), 0);

    // priority
    cfg(0, 32'hA); cfg(1, 32'hA);
    pulse(4'hA);
    retire(32'h80);
    chk("t2_id1", 32'(bus.active_id), 1);
    chk("t2_tpc1", bus.take_pc, 32'h104);
    step(); iret();
    retire(32'h84);
    chk("t2_id3", 32'(bus.active_id), 3);
    chk("t2_tpc3", bus.take_pc, 32'h10C);
    step(); iret();

    // level retakes, edge does not
    cfg(0, 1); cfg(1, 0);
    bus.irq = 1;
    retire(32'h90);
    chk("t3_lvl1", bus.take_pc, 32'h100);
    step(); iret();
    retire(32'h94);
    chk("t3_lvl2", 32'(bus.take), 1);
    step(); iret();
    bus.irq = 0;
    cfg(4, 1); cfg(1, 1);
    bus.irq = 1;
    step();
    retire(32'h98);
    chk("t3_edge1", 32'(bus.take), 1);
    step(); iret();
    retire(32'h9C);
    chk("t3_edge2", 32'(bus.take), 0);
    bus.irq = 0;
    step();

    // masking and W1C
    cfg(0, 0); cfg(1, 4);
    pulse(4);
    chk("t4_mask", 32'(bus.pending), 4);
    retire(32'hA0);
    chk("t4_notake", 32'(bus.take), 0);
    bus.irq = 4;
    cfg(4, 4);
    chk("t4_setwins", 32'(bus.pending), 4);
    bus.irq = 0;
    cfg(4, 4);
    chk("t4_w1c", 32'(bus.pending), 0);

    // iret collision and no nesting
    cfg(0, 4);
    pulse(4);
    bus.cpu_iret = 1;
    retire(32'hA0);
    chk("t5_coll", 32'(bus.take), 0);
    retire(32'hA4);
    chk("t5_take", 32'(bus.take), 1);
    step();
    cfg(3, 1);
    pulse(4);
    retire(32'hA8);
    chk("t5_nonest", 32'(bus.take), 0);
    iret();
    retire(32'hAC);
    chk("t5_after", 32'(bus.take), 1);
    chk("t5_epc", bus.epc, 32'hAC);
    step(); iret();

    // reset mid-service
    pulse(4);
    retire(32'hB0);
    step();
    bus.irq = 4;
    rst_n = 0;
    #1;
    chk("t6_svc", 32'(bus.in_service), 0);
    chk("t6_epc", bus.epc, 0);
    step(2);
    rst_n = 1;
    step();
    cfg(0, 4); cfg(1, 4);
    chk("t6_fresh", 32'(bus.pending), 4);
    cfg(3, 1);
    retire(32'hC0);
    chk("t6_tpc", bus.take_pc, 32'h108);
    step(); iret();
    bus.irq = 0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_intr_ctrl.md
Name: cpu_intr_ctrl

Overview:
Multi-source interrupt controller for the CPU core. It generalises the core's single interrupt request, enable, saved PC and vector into N_SRC prioritised sources. Each source has its own enable and level/edge mode, and gets a computed vector. The block sits beside the execute stage: it samples the instruction-retire boundary, issues a one-cycle redirect with the target vector, saves the return PC, and restores state on return-from-interrupt.

Parameters:
N_SRC, 4, number of interrupt sources (1..16)
XLEN, 32, PC/vector/config data width
VEC_RESET, 32'h0000_0100, reset value of vector base register

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
irq  in  N_SRC  raw interrupt request lines, synchronous to clk
cfg_we  in  1  config write strobe
cfg_sel  in  3  0=enable mask, 1=edge-mode mask, 2=vector base, 3=global IE (bit0), 4=pending write-1-to-clear
cfg_wdata  in  XLEN  config write data (masks use low N_SRC bits)
cpu_retire  in  1  an instruction retires this cycle (legal interrupt boundary)
cpu_pc  in  XLEN  PC of the next instruction, valid with cpu_retire
cpu_iret  in  1  return-from-interrupt instruction retires this cycle
take  out  1  one-cycle redirect pulse
take_pc  out  XLEN  vector target, valid while take=1, else 0
epc  out  XLEN  saved return PC
in_service  out  1  handler active
active_id  out  $clog2(N_SRC) (min 1)  source being serviced
pending  out  N_SRC  pending vector

Behaviour:
- Reset values: all outputs 0; enable=0, edge mask=0, IE=0, PIE=0; vec_base=VEC_RESET; irq_q=0; state IDLE.
- Edge detect: irq_q <= irq each cycle. Edge source: pending[i] set on irq[i] & ~irq_q[i]. It holds until taken or cleared by write-1-to-clear. If set and clear occur in the same cycle, set wins.
- Level source: pending[i] = irq[i] (combinational view, no latch). Write-1-to-clear has no effect on level sources.
- Eligible request: req = pending & enable. Winner = lowest index set in req.
- FSM IDLE:
  - On a clock edge with IE=1, |req, cpu_retire=1 and cpu_iret=0: epc<=cpu_pc, active_id<=winner, PIE<=IE, IE<=0, clear pending[winner] if edge mode. Go to TAKE.
- FSM TAKE (exactly 1 cycle):
  - take=1, take_pc = vec_base + (winner << 2), computed modulo 2^XLEN.
  - in_service=1. Go to SERVICE.
- FSM SERVICE: no nesting; requests are ignored regardless of IE writes.
  - On cpu_iret: IE<=PIE, in_service<=0. Go to IDLE.
  - epc and active_id hold their value after return.
- cpu_iret in IDLE or TAKE: ignored.
- cpu_iret and a pending request in the same IDLE cycle: no take. The request is re-evaluated at the next retire.
- cfg write to IE during TAKE/SERVICE updates IE only; PIE is unchanged.
- Config writes take effect the next cycle. A cfg_we in the same cycle as a take decision uses the pre-write values.
- Enable mask change does not clear pending; a masked edge stays latched.
- Latency: irq edge at cycle t → pending at t+1 → take pulse at the first retire edge ≥ t+1, visible the cycle after.
- Mid-operation reset: return to reset values immediately and asynchronously, including during TAKE/SERVICE.

Test Plan:
- Single edge: vec_base=0x100, enable=0b0100, edge=0b0100, IE=1; pulse irq[2]; retire with cpu_pc=0x40 → take=1 one cycle, take_pc=0x108, epc=0x40, active_id=2, IE=0; iret → IE=1, in_service=0.
- Priority: irq[3] and irq[1] both edge-pending, both enabled → first take active_id=1, take_pc=0x104. After iret and the next retire → active_id=3, take_pc=0x10C.
- Level vs edge: source 0 in level mode held high, handled and iret'd while still high → retakes at the next retire. The same source in edge mode, held high → no retake.
- Masking/W1C: edge on masked irq[2] → pending[2]=1, no take. Write cfg_sel=4 data 0x4 in the same cycle as a new edge → pending[2] stays 1.
- Simultaneous/no-nesting: iret and request in the same cycle → no take that cycle. A request during SERVICE with IE rewritten to 1 → no take until after iret.
- Reset mid-SERVICE: drop rst_n → all outputs 0, vec_base=0x100, irq_q cleared. After release, a held-high edge-mode irq registers a fresh edge.
